if_prefetch_queue: RTL

//  Instruction-fetch front end for the RV32 pipeline; feeds the IF/ID register.

---
 rtl/if_prefetch_queue_if.sv | 34 +++
 rtl/if_prefetch_queue.sv | 94 +++++++++
 2 files changed

// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle: instruction RAM request/response, ID redirect, and
// the valid/ready head-of-queue port toward decode.
interface if_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [CW-1:0] occupancy;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, occupancy,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, occupancy,
    output out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues word-addressed fetches, buffers
// {pc, instr} pairs in a small FIFO, and flushes/restarts on ID redirects.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input logic               clock,
  input logic               reset,
  if_prefetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = CW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          valid_q;
  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;

  logic          pop;
  logic          push;
  logic          req;
  logic [31:0]   addr;
  logic [AW-1:0] committed;
  logic [CW-1:0] count_n;

  // Slot accounting counts the response due this cycle and frees a popped
  // head early, so a request can issue in the same cycle as a pop at full.
  always_comb begin
    pop       = valid_q & bus.out_ready;
    push      = inflight & ~bus.redirect_valid;
    committed = AW'(count) - AW'(pop) + AW'(inflight);
    req       = reset & (bus.redirect_valid | (committed < AW'(DEPTH)));
    addr      = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
    count_n   = count;
    if (bus.redirect_valid) begin
      count_n = '0;
    end else begin
      count_n = count - CW'(pop) + CW'(push);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      valid_q     <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      count    <= count_n;
      valid_q  <= (count_n != '0);
      inflight <= req;
      if (req) begin
        inflight_pc <= addr;
        fetch_pc    <= addr + PC_STEP;
      end
      // A redirect drops both the queued entries and the response arriving now.
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= inflight_pc;
          instr_mem[wr_ptr] <= bus.imem_rdata;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_instr = instr_mem[rd_ptr];
  assign bus.occupancy = count;

endmodule
